// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the 5-stage pipeline hazard controller:
//   - FSM state encodings (ST_RUN, ST_LOAD_STALL, ST_HOLD)
//   - EX operand forwarding selects (FWD_NONE, FWD_WB, FWD_MEM)
//   - the hard-wired zero register number
//   - fwd_sel(): forwarding source priority for one EX operand
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_HOLD       = 2'd2
   } state_t;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // MEM wins over WB because it holds the younger result for the same register.
   // Register zero is never forwarded: writes to it are discarded.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic       mem_regwrite,
      input logic [4:0] mem_writereg,
      input logic       wb_regwrite,
      input logic [4:0] wb_writereg
   );
      logic [1:0] sel;
      if (mem_regwrite && (mem_writereg != REG_ZERO) && (mem_writereg == src)) begin
         sel = FWD_MEM;
      end else if (wb_regwrite && (wb_writereg != REG_ZERO) && (wb_writereg == src)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_NONE;
      end
      return sel;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// -----------------------------------------------------------------------------
// forwarding_unit
// Purely combinational EX-stage operand forwarding select.
// Ports:
//   EX_rs, EX_rt                 in  source registers of the EX instruction
//   MEM_RegWrite, MEM_WriteReg   in  MEM-stage write-back info
//   WB_RegWrite, WB_WriteReg     in  WB-stage write-back info
//   ForwardA, ForwardB           out operand A (rs) / B (rt) source select
// -----------------------------------------------------------------------------
module forwarding_unit
   import hazard_pkg::*;
(
   input  logic [4:0] EX_rs,
   input  logic [4:0] EX_rt,
   input  logic       MEM_RegWrite,
   input  logic [4:0] MEM_WriteReg,
   input  logic       WB_RegWrite,
   input  logic [4:0] WB_WriteReg,
   output logic [1:0] ForwardA,
   output logic [1:0] ForwardB
);

   assign ForwardA = fwd_sel(EX_rs, MEM_RegWrite, MEM_WriteReg, WB_RegWrite, WB_WriteReg);
   assign ForwardB = fwd_sel(EX_rt, MEM_RegWrite, MEM_WriteReg, WB_RegWrite, WB_WriteReg);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and sequencing controller for a 5-stage MIPS pipeline.
// Ports:
//   clk, reset (async, active-low)
//   hold_req                       in  external freeze request
//   ID_rs, ID_rt, ID_uses_rt       in  ID instruction sources
//   ID_jump                        in  jump decoded in ID
//   EX_rs, EX_rt                   in  EX instruction sources
//   EX_MemRead, EX_WriteReg        in  EX load info
//   MEM_RegWrite, MEM_WriteReg     in  MEM write-back info
//   MEM_branch_taken               in  branch resolved taken in MEM
//   WB_RegWrite, WB_WriteReg       in  WB write-back info
//   *_enable                       out PC / pipeline register enables
//   *_flush                        out synchronous clears of pipeline registers
//   ForwardA, ForwardB             out EX operand forwarding selects
//   stall_cycles, flush_events     out saturating performance counters
//   state                          out current FSM state (debug)
// Enables, flushes and forwarding are combinational; state and counters are
// registered.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 hold_req,
   input  logic [4:0]           ID_rs,
   input  logic [4:0]           ID_rt,
   input  logic                 ID_uses_rt,
   input  logic                 ID_jump,
   input  logic [4:0]           EX_rs,
   input  logic [4:0]           EX_rt,
   input  logic                 EX_MemRead,
   input  logic [4:0]           EX_WriteReg,
   input  logic                 MEM_RegWrite,
   input  logic [4:0]           MEM_WriteReg,
   input  logic                 MEM_branch_taken,
   input  logic                 WB_RegWrite,
   input  logic [4:0]           WB_WriteReg,
   output logic                 PC_enable,
   output logic                 IF_ID_enable,
   output logic                 ID_EX_enable,
   output logic                 EX_MEM_enable,
   output logic                 MEM_WB_enable,
   output logic                 IF_ID_flush,
   output logic                 ID_EX_flush,
   output logic                 EX_MEM_flush,
   output logic [1:0]           ForwardA,
   output logic [1:0]           ForwardB,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_events,
   output logic [1:0]           state
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

   state_t                r_state;
   state_t                w_next_state;
   logic [CNT_WIDTH-1:0]  r_stall_cycles;
   logic [CNT_WIDTH-1:0]  r_flush_events;
   logic                  w_lu;
   logic                  w_flush_evt;
   logic                  w_stall_evt;

   forwarding_unit u_fwd (
      .EX_rs        (EX_rs),
      .EX_rt        (EX_rt),
      .MEM_RegWrite (MEM_RegWrite),
      .MEM_WriteReg (MEM_WriteReg),
      .WB_RegWrite  (WB_RegWrite),
      .WB_WriteReg  (WB_WriteReg),
      .ForwardA     (ForwardA),
      .ForwardB     (ForwardB)
   );

   // Load in EX writes a register the ID instruction reads (r0 never counts).
   assign w_lu = EX_MemRead && (EX_WriteReg != REG_ZERO) &&
                 ((EX_WriteReg == ID_rs) || (ID_uses_rt && (EX_WriteReg == ID_rt)));

   // Priority action resolution: hold > branch > load-use > jump > run.
   always_comb begin
      PC_enable     = 1'b1;
      IF_ID_enable  = 1'b1;
      ID_EX_enable  = 1'b1;
      EX_MEM_enable = 1'b1;
      MEM_WB_enable = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_flush   = 1'b0;
      EX_MEM_flush  = 1'b0;
      w_flush_evt   = 1'b0;
      w_next_state  = ST_RUN;
      if (hold_req) begin
         PC_enable     = 1'b0;
         IF_ID_enable  = 1'b0;
         ID_EX_enable  = 1'b0;
         EX_MEM_enable = 1'b0;
         MEM_WB_enable = 1'b0;
         w_next_state  = ST_HOLD;
      end else if (MEM_branch_taken) begin
         IF_ID_flush  = 1'b1;
         ID_EX_flush  = 1'b1;
         EX_MEM_flush = 1'b1;
         w_flush_evt  = 1'b1;
      end else if (w_lu && (r_state != ST_LOAD_STALL)) begin
         // Masked in LOAD_STALL so each hazard yields exactly one bubble;
         // still live in HOLD so a pending hazard is taken on release.
         PC_enable    = 1'b0;
         IF_ID_enable = 1'b0;
         ID_EX_flush  = 1'b1;
         w_next_state = ST_LOAD_STALL;
      end else if (ID_jump) begin
         IF_ID_flush = 1'b1;
         w_flush_evt = 1'b1;
      end else begin
         w_next_state = ST_RUN;
      end
   end

   // Stall cycles are counted by the state the pipeline is sitting in.
   always_comb begin
      w_stall_evt = 1'b0;
      case (r_state)
         ST_LOAD_STALL: w_stall_evt = 1'b1;
         ST_HOLD:       w_stall_evt = 1'b1;
         default:       w_stall_evt = 1'b0;
      endcase
   end

   // FSM state register and saturating performance counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= ST_RUN;
         r_stall_cycles <= CNT_ZERO;
         r_flush_events <= CNT_ZERO;
      end else begin
         r_state <= w_next_state;
         if (w_stall_evt && (r_stall_cycles != CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + CNT_ONE;
         end else begin
            r_stall_cycles <= r_stall_cycles;
         end
         if (w_flush_evt && (r_flush_events != CNT_MAX)) begin
            r_flush_events <= r_flush_events + CNT_ONE;
         end else begin
            r_flush_events <= r_flush_events;
         end
      end
   end

   assign state        = r_state;
   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;

endmodule
